// File: rtl/borrow_select_subtractor_seq.sv
// borrow_select_subtractor_seq
//   Multi-cycle borrow-select subtractor: diff = din_a - din_b - bin.
//   One SLICE-bit group is resolved per clock. Both borrow-in candidates of
//   the slice are formed every cycle and the registered borrow picks one.
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   start              request, accepted in IDLE or DONE
//   din_a, din_b, bin  operands, captured when start is accepted
//   busy               high while slices are being resolved
//   done               one-cycle pulse, result valid
//   diff, bout, ovf    difference, borrow-out, signed overflow (held)
module borrow_select_subtractor_seq #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int NSL = WIDTH / SLICE;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                        state_q, state_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic                          brw_q, brw_d;
  logic [NSL-1:0][SLICE-1:0]     a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic                          bout_q, bout_d, ovf_q, ovf_d;

  logic [SLICE-1:0]              a_s, b_s;
  logic [SLICE:0]                d0, d1, sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      brw_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      brw_q   <= brw_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    brw_d   = brw_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    // Both candidates are SLICE+1 bits; the top bit is the slice borrow-out.
    a_s = a_q[idx_q];
    b_s = b_q[idx_q];
    d0  = {1'b0, a_s} - {1'b0, b_s};
    d1  = d0 - {{SLICE{1'b0}}, 1'b1};
    sel = brw_q ? d1 : d0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = din_a;
          b_d     = din_b;
          brw_d   = bin;
          idx_d   = '0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        diff_d[idx_q] = sel[SLICE-1:0];
        brw_d         = sel[SLICE];
        idx_d         = idx_q + IW'(1);
        if (idx_q == IW'(NSL-1)) begin
          idx_d   = '0;
          state_d = DONE;
          bout_d  = sel[SLICE];
          // Top slice holds the MSB, so the new diff MSB is sel[SLICE-1].
          ovf_d   = (a_q[NSL-1][SLICE-1] != b_q[NSL-1][SLICE-1]) &&
                    (sel[SLICE-1] != a_q[NSL-1][SLICE-1]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
endmodule
